// File: rtl/tf_stage_seq.sv
// Stage/iteration sequencer driving the twiddle-factor generator.
// Optional macro TFS_STALL_EN adds a stall input that freezes sequencing.
module tf_stage_seq #(
    parameter int D_WIDTH   = 64,
    parameter int NUM_STAGE = 4,
    parameter int ITE_NUM   = 16,
    parameter int DRAIN_CYC = 3
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [D_WIDTH-1:0] modulus_in,
`ifdef TFS_STALL_EN
    input  logic               stall,
`endif
    output logic               busy,
    output logic               done,
    output logic               TF_ren,
    output logic               TF_wen,
    output logic               LAST_STAGE,
    output logic [2:0]         l,
    output logic [2:0]         it_depth_cnt,
    output logic [D_WIDTH-1:0] ite_sw_cnt,
    output logic [D_WIDTH-1:0] ite_sw_cnt_ite3,
    output logic [D_WIDTH-1:0] modulus
);

    localparam int BW = $clog2(ITE_NUM);
    localparam int DW = (DRAIN_CYC > 1) ? $clog2(DRAIN_CYC) : 1;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    logic [1:0]         st;
    logic [BW-1:0]      beat;
    logic [DW-1:0]      dcnt;
    logic [2:0]         lreg;
    logic [D_WIDTH-1:0] mod_q;

    logic is_idle, is_run, is_drain, is_done;
    logic last_beat, last_drain, last_pass, frz;

    assign is_idle    = (st == S_IDLE);
    assign is_run     = (st == S_RUN);
    assign is_drain   = (st == S_DRAIN);
    assign is_done    = (st == S_DONE);
    assign last_beat  = (beat == BW'(ITE_NUM - 1));
    assign last_drain = (dcnt == DW'(DRAIN_CYC - 1));
    assign last_pass  = (lreg == 3'(NUM_STAGE - 1));
    assign modulus    = mod_q;

`ifdef TFS_STALL_EN
    assign frz = stall && (is_run || is_drain);
`else
    assign frz = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st    <= S_IDLE;
            beat  <= '0;
            dcnt  <= '0;
            lreg  <= '0;
            mod_q <= '0;
        end else if (!frz) begin
            unique case (1'b1)
                is_idle: begin
                    if (start) begin
                        st    <= S_RUN;
                        beat  <= '0;
                        dcnt  <= '0;
                        lreg  <= '0;
                        mod_q <= modulus_in;
                    end
                end
                is_run: begin
                    if (last_beat) begin
                        beat <= '0;
                        dcnt <= '0;
                        st   <= S_DRAIN;
                    end else begin
                        beat <= beat + BW'(1);
                    end
                end
                is_drain: begin
                    if (last_drain) begin
                        dcnt <= '0;
                        if (last_pass) begin
                            st <= S_DONE;
                        end else begin
                            lreg <= lreg + 3'd1;
                            st   <= S_RUN;
                        end
                    end else begin
                        dcnt <= dcnt + DW'(1);
                    end
                end
                is_done: st <= S_IDLE;
                default: st <= S_IDLE;
            endcase
        end
    end

    // Outputs trail the state by one register; a stall holds them, strobes off.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy            <= 1'b0;
            done            <= 1'b0;
            TF_ren          <= 1'b0;
            TF_wen          <= 1'b0;
            LAST_STAGE      <= 1'b0;
            l               <= '0;
            it_depth_cnt    <= '0;
            ite_sw_cnt      <= '0;
            ite_sw_cnt_ite3 <= '0;
        end else if (frz) begin
            TF_ren <= 1'b0;
            TF_wen <= 1'b0;
        end else begin
            busy            <= is_run || is_drain;
            done            <= is_done;
            TF_ren          <= is_run;
            TF_wen          <= is_run && (beat[2:0] == 3'd7);
            LAST_STAGE      <= is_run && last_pass;
            l               <= is_idle ? 3'd0 : lreg;
            it_depth_cnt    <= is_run ? beat[2:0] : 3'd0;
            ite_sw_cnt      <= is_run ? D_WIDTH'(beat) : '0;
            ite_sw_cnt_ite3 <= is_run ? D_WIDTH'(beat >> 3) : '0;
        end
    end

endmodule
